// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle controller and its datapath:
// opcodes, FSM states, ALU operations and mux selects.
package multi_cycle_control_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_OR    = 6'b010010;
    localparam logic [5:0] OP_ORI   = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_LHU   = 6'b110010;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_REG    = 2'd2;
    localparam logic [1:0] PC_JUMP   = 2'd3;

    localparam logic [1:0] DST_RA = 2'd0;
    localparam logic [1:0] DST_RT = 2'd1;
    localparam logic [1:0] DST_RD = 2'd2;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_LD  = 4'd6,
        S_EXE_BR = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_RTYPE, CLS_ALUI, CLS_LOAD,
        CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_HALT
    } opClass_t;

endpackage

// File: rtl/multi_cycle_control_opcode_decode.sv
// Combinational opcode classification: instruction class, ALU operation,
// immediate extension mode and ALU operand selects.
import multi_cycle_control_pkg::*;

module opcode_decode (
    input  logic [5:0] opcode,
    output opClass_t   opClass,
    output logic [2:0] aluOp,
    output logic       extSel,
    output logic       aluSrcA,
    output logic       aluSrcB
);

    always_comb begin
        opClass = CLS_NOP;
        aluOp   = ALU_ADD;
        extSel  = 1'b1;
        aluSrcA = 1'b0;
        aluSrcB = 1'b0;
        case (opcode)
            OP_ADD:   opClass = CLS_RTYPE;
            OP_SUB:   begin opClass = CLS_RTYPE; aluOp = ALU_SUB; end
            OP_AND:   begin opClass = CLS_RTYPE; aluOp = ALU_AND; end
            OP_OR:    begin opClass = CLS_RTYPE; aluOp = ALU_OR;  end
            OP_SLT:   begin opClass = CLS_RTYPE; aluOp = ALU_SLT; end
            OP_SLL:   begin opClass = CLS_RTYPE; aluOp = ALU_SLL; aluSrcA = 1'b1; end
            OP_ADDIU: begin opClass = CLS_ALUI;  aluSrcB = 1'b1; end
            OP_ANDI:  begin opClass = CLS_ALUI;  aluOp = ALU_AND; aluSrcB = 1'b1; extSel = 1'b0; end
            OP_ORI:   begin opClass = CLS_ALUI;  aluOp = ALU_OR;  aluSrcB = 1'b1; extSel = 1'b0; end
            OP_SLTI:  begin opClass = CLS_ALUI;  aluOp = ALU_SLT; aluSrcB = 1'b1; end
            OP_LW, OP_LHU: begin opClass = CLS_LOAD;  aluSrcB = 1'b1; end
            OP_SW:    begin opClass = CLS_STORE; aluSrcB = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin opClass = CLS_BRANCH; aluOp = ALU_SUB; end
            OP_J, OP_JR, OP_JAL: opClass = CLS_JUMP;
            OP_HALT:  opClass = CLS_HALT;
            default:  opClass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: state register, retired-instruction counter
// and per-state control decode.
import multi_cycle_control_pkg::*;

module multi_cycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        sign,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        RegWr,
    output logic        WrRegDSrc,
    output logic        getHW,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic        mRD,
    output logic        mWR,
    output logic        DBDataSrc,
    output logic [1:0]  RegDst,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUOp,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    state_t     stateReg, stateNext;
    opClass_t   opClass;
    logic [2:0] decAluOp;
    logic       decExtSel, decSrcA, decSrcB;
    logic       branchTaken;

    opcode_decode uDecode (
        .opcode (opcode),
        .opClass(opClass),
        .aluOp  (decAluOp),
        .extSel (decExtSel),
        .aluSrcA(decSrcA),
        .aluSrcB(decSrcB)
    );

    assign branchTaken = (opcode == OP_BEQ  &&  zero) ||
                         (opcode == OP_BNE  && !zero) ||
                         (opcode == OP_BLTZ &&  sign);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= S_IF;
            retired  <= 32'd0;
        end else begin
            stateReg <= stateNext;
            if (PCWre) retired <= retired + 32'd1;
        end
    end

    assign state = stateReg;

    // All outputs are held at 0 while rst is high, including the IF strobes.
    always_comb begin
        stateNext = stateReg;
        PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; RegWr = 1'b0;
        WrRegDSrc = 1'b0; getHW = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
        ExtSel = 1'b0; mRD = 1'b0; mWR = 1'b0; DBDataSrc = 1'b0;
        RegDst = DST_RA; PCSrc = PC_NEXT; ALUOp = ALU_ADD;
        if (!rst) begin
            unique case (stateReg)
                S_IF: begin
                    IRWre = 1'b1; InsMemRW = 1'b1;
                    stateNext = S_ID;
                end
                S_ID: begin
                    case (opClass)
                        CLS_RTYPE, CLS_ALUI:  stateNext = S_EXE_AL;
                        CLS_LOAD, CLS_STORE: stateNext = S_EXE_LS;
                        CLS_BRANCH:          stateNext = S_EXE_BR;
                        CLS_HALT:            stateNext = S_HALT;
                        default: begin
                            // Jumps and unknown opcodes retire straight out of ID.
                            stateNext = S_IF;
                            PCWre = 1'b1;
                            if (opClass == CLS_JUMP)
                                PCSrc = (opcode == OP_JR) ? PC_REG : PC_JUMP;
                            if (opcode == OP_JAL) begin
                                RegWr = 1'b1; RegDst = DST_RA; WrRegDSrc = 1'b1;
                            end
                        end
                    endcase
                end
                S_EXE_AL: begin
                    ALUSrcA = decSrcA; ALUSrcB = decSrcB; ExtSel = decExtSel;
                    ALUOp = decAluOp;
                    stateNext = S_WB_AL;
                end
                S_WB_AL: begin
                    RegWr = 1'b1;
                    RegDst = (opClass == CLS_RTYPE) ? DST_RD : DST_RT;
                    PCWre = 1'b1;
                    stateNext = S_IF;
                end
                S_EXE_LS: begin
                    ALUSrcB = decSrcB; ExtSel = decExtSel; ALUOp = ALU_ADD;
                    stateNext = S_MEM;
                end
                S_MEM: begin
                    if (opClass == CLS_STORE) begin
                        mWR = 1'b1; PCWre = 1'b1;
                        stateNext = S_IF;
                    end else begin
                        mRD = 1'b1;
                        stateNext = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    RegWr = 1'b1; RegDst = DST_RT; DBDataSrc = 1'b1;
                    getHW = (opcode == OP_LHU);
                    PCWre = 1'b1;
                    stateNext = S_IF;
                end
                S_EXE_BR: begin
                    ALUSrcA = decSrcA; ALUSrcB = decSrcB; ExtSel = decExtSel;
                    ALUOp = ALU_SUB;
                    PCWre = 1'b1;
                    PCSrc = branchTaken ? PC_BRANCH : PC_NEXT;
                    stateNext = S_IF;
                end
                S_HALT:  stateNext = S_HALT;
                default: stateNext = S_IF;
            endcase
        end
    end

endmodule
